lap_log_ctrl: RTL and testbench

- Controller that owns a one-read/one-write BRAM as a circular log of chronometer lap times.
- Sequences writes of captured laps, serves indexed read-back (0 = newest) to the display/scroll logic, and scrubs the memory to zero after reset or on command, because the BRAM has no reset.
- Sits between the lap-capture unit, the display formatter and a RAM instance in the parent.

---
 rtl/lap_log_ctrl_pkg.sv | 14 +
 rtl/lap_log_rd_pipe.sv | 37 +++
 rtl/lap_log_ctrl.sv | 136 +++++++++++++
 tb/tb_lap_log_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lap_log_ctrl_pkg.sv
// Shared chrono definitions: controller state encoding, read latency and
// the default lap-RAM geometry used by the controller and its RAM.
package lap_log_ctrl_pkg;

    typedef enum logic {
        SCRUB = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int unsigned READ_LATENCY      = 2;
    localparam int unsigned LAP_RAM_WIDTH     = 16;
    localparam int unsigned LAP_RAM_ADDR_BITS = 9;

endpackage

// File: rtl/lap_log_rd_pipe.sv
// Valid/hit shift pipeline that tracks read requests while the RAM fetches.
module lap_log_rd_pipe
    import lap_log_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = READ_LATENCY
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic req_i,
    input  logic hit_i,
    output logic valid_o,
    output logic hit_o
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [LATENCY-1:0] hit_q, hit_d;

    always_comb begin
        valid_d = {valid_q[LATENCY-2:0], req_i};
        hit_d   = {hit_q[LATENCY-2:0], req_i & hit_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_q <= '0;
            hit_q   <= '0;
        end else begin
            valid_q <= valid_d;
            hit_q   <= hit_d;
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign hit_o   = hit_q[LATENCY-1];

endmodule

// File: rtl/lap_log_ctrl.sv
// Circular lap-time log controller: scrubs the BRAM after reset/clear,
// appends captured laps and serves age-indexed reads (0 = newest).
module lap_log_ctrl
    import lap_log_ctrl_pkg::*;
#(
    parameter int unsigned RAM_WIDTH     = LAP_RAM_WIDTH,
    parameter int unsigned RAM_ADDR_BITS = LAP_RAM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     lap_valid,
    input  logic [RAM_WIDTH-1:0]     lap_time,
    output logic                     lap_ready,
    input  logic                     rd_req,
    input  logic [RAM_ADDR_BITS-1:0] rd_index,
    output logic                     rd_valid,
    output logic                     rd_hit,
    output logic [RAM_WIDTH-1:0]     rd_data,
    output logic [RAM_ADDR_BITS:0]   lap_count,
    output logic                     busy,
    output logic [RAM_ADDR_BITS-1:0] ram_rd_addr,
    input  logic [RAM_WIDTH-1:0]     ram_rd_data,
    output logic [RAM_ADDR_BITS-1:0] ram_wr_addr,
    output logic [RAM_WIDTH-1:0]     ram_wr_data,
    output logic                     ram_we
);

    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;
    localparam logic [RAM_ADDR_BITS:0]   CNT_ONE  = 1;

    state_e                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] scrub_addr_q, scrub_addr_d;
    logic [RAM_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [RAM_ADDR_BITS:0]   lap_count_q, lap_count_d;
    logic                     ram_we_q, ram_we_d;
    logic [RAM_ADDR_BITS-1:0] ram_wr_addr_q, ram_wr_addr_d;
    logic [RAM_WIDTH-1:0]     ram_wr_data_q, ram_wr_data_d;
    logic [RAM_ADDR_BITS-1:0] ram_rd_addr_q, ram_rd_addr_d;
    logic                     rd_accept;
    logic                     rd_in_range;

    always_comb begin
        state_d       = state_q;
        scrub_addr_d  = scrub_addr_q;
        wr_ptr_d      = wr_ptr_q;
        lap_count_d   = lap_count_q;
        ram_we_d      = 1'b0;
        ram_wr_addr_d = ram_wr_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        ram_rd_addr_d = ram_rd_addr_q;
        rd_accept     = 1'b0;
        rd_in_range   = ({1'b0, rd_index} < lap_count_q);

        if (clear) begin
            state_d      = SCRUB;
            scrub_addr_d = '0;
            wr_ptr_d     = '0;
            lap_count_d  = '0;
        end else begin
            case (state_q)
                SCRUB: begin
                    ram_we_d      = 1'b1;
                    ram_wr_addr_d = scrub_addr_q;
                    ram_wr_data_d = '0;
                    scrub_addr_d  = scrub_addr_q + ADDR_ONE;
                    if (scrub_addr_q == '1) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    // Read address uses the pre-write pointer so a same-cycle
                    // lap does not shift the age of the entry being read.
                    if (rd_req) begin
                        rd_accept     = 1'b1;
                        ram_rd_addr_d = wr_ptr_q - ADDR_ONE - rd_index;
                    end
                    if (lap_valid) begin
                        ram_we_d      = 1'b1;
                        ram_wr_addr_d = wr_ptr_q;
                        ram_wr_data_d = lap_time;
                        wr_ptr_d      = wr_ptr_q + ADDR_ONE;
                        if (!lap_count_q[RAM_ADDR_BITS]) begin
                            lap_count_d = lap_count_q + CNT_ONE;
                        end
                    end
                end
                default: state_d = SCRUB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SCRUB;
            scrub_addr_q  <= '0;
            wr_ptr_q      <= '0;
            lap_count_q   <= '0;
            ram_we_q      <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
            ram_rd_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            scrub_addr_q  <= scrub_addr_d;
            wr_ptr_q      <= wr_ptr_d;
            lap_count_q   <= lap_count_d;
            ram_we_q      <= ram_we_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_rd_addr_q <= ram_rd_addr_d;
        end
    end

    lap_log_rd_pipe #(
        .LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(clear),
        .req_i  (rd_accept),
        .hit_i  (rd_in_range),
        .valid_o(rd_valid),
        .hit_o  (rd_hit)
    );

    assign rd_data     = rd_hit ? ram_rd_data : '0;
    assign lap_count   = lap_count_q;
    assign busy        = (state_q == SCRUB);
    assign lap_ready   = (state_q == IDLE);
    assign ram_rd_addr = ram_rd_addr_q;
    assign ram_wr_addr = ram_wr_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_we      = ram_we_q;

endmodule

// File: tb/tb_lap_log_ctrl.sv
// Bench for lap_log_ctrl (DEPTH=8) with a read-first RAM and a queue-based
// model of the lap log checked every cycle.
module tb_lap_log_ctrl;

    localparam int unsigned W     = 16;
    localparam int unsigned AB    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          lap_valid;
    logic [W-1:0]  lap_time;
    logic          lap_ready;
    logic          rd_req;
    logic [AB-1:0] rd_index;
    logic          rd_valid;
    logic          rd_hit;
    logic [W-1:0]  rd_data;
    logic [AB:0]   lap_count;
    logic          busy;
    logic [AB-1:0] ram_rd_addr;
    logic [W-1:0]  ram_rd_data;
    logic [AB-1:0] ram_wr_addr;
    logic [W-1:0]  ram_wr_data;
    logic          ram_we;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    lap_log_ctrl #(
        .RAM_WIDTH    (W),
        .RAM_ADDR_BITS(AB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .lap_valid  (lap_valid),
        .lap_time   (lap_time),
        .lap_ready  (lap_ready),
        .rd_req     (rd_req),
        .rd_index   (rd_index),
        .rd_valid   (rd_valid),
        .rd_hit     (rd_hit),
        .rd_data    (rd_data),
        .lap_count  (lap_count),
        .busy       (busy),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .ram_we     (ram_we)
    );

    // Read-first RAM; garbage fill while rst is high stands in for power-up contents.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hDEAD ^ 16'(i);
        end else if (ram_we) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: log as newest-first queue, scrub as a cycle countdown,
    // read responses as a list of (due cycle, hit, data).
    typedef struct {
        int unsigned  due;
        logic         hit;
        logic [W-1:0] data;
    } resp_t;

    logic [W-1:0] log_q[$];
    resp_t        pend[$];
    int unsigned  cyc        = 0;
    int unsigned  scrub_left = DEPTH;

    always @(posedge clk) begin : model
        resp_t r;
        cyc++;
        if (rst || clear) begin
            scrub_left = DEPTH;
            log_q.delete();
            pend.delete();
        end else if (scrub_left > 0) begin
            scrub_left--;
        end else begin
            if (rd_req) begin
                r.due  = cyc + 1;
                r.hit  = (int'(rd_index) < log_q.size());
                r.data = r.hit ? log_q[rd_index] : '0;
                pend.push_back(r);
            end
            if (lap_valid) begin
                log_q.push_front(lap_time);
                if (log_q.size() > DEPTH) void'(log_q.pop_back());
            end
        end
    end

    always @(posedge clk) begin : monitor
        resp_t r;
        #1;
        if (!rst) begin
            check_eq("busy", busy, scrub_left > 0);
            check_eq("lap_ready", lap_ready, scrub_left == 0);
            check_eq("lap_count", lap_count, log_q.size());
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                check_eq("rd_valid", rd_valid, 1'b1);
                check_eq("rd_hit", rd_hit, r.hit);
                check_eq("rd_data", rd_data, r.data);
            end else begin
                check_eq("rd_valid_idle", rd_valid, 1'b0);
            end
        end
    end

    // Counts the initial scrub's zero writes issued in address order.
    int unsigned scrub_wr_cnt = 0;
    logic        scrub_cnt_en = 1'b1;
    always @(posedge clk) begin
        if (!rst && scrub_cnt_en && ram_we && ram_wr_data == '0 &&
            ram_wr_addr == scrub_wr_cnt[AB-1:0]) begin
            scrub_wr_cnt <= scrub_wr_cnt + 1;
        end
    end

    task automatic drive(input logic lv, input logic [W-1:0] lt, input logic rq,
                         input logic [AB-1:0] ri, input logic clr);
        lap_valid = lv;
        lap_time  = lt;
        rd_req    = rq;
        rd_index  = ri;
        clear     = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        lap_valid = 1'b0;
        lap_time  = '0;
        rd_req    = 1'b0;
        rd_index  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check_eq("scrub_done", busy, 1'b0);
        idle(2);
        scrub_cnt_en = 1'b0;
        check_eq("scrub_writes", scrub_wr_cnt, DEPTH);
        for (int i = 0; i < DEPTH; i++) check_eq("scrub_zero", mem[i], '0);

        for (int i = 1; i <= 3; i++) drive(1'b1, 16'h0100 + 16'(i), 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, AB'(i), 1'b0);
        idle(4);

        for (int i = 1; i <= 10; i++) drive(1'b1, 16'h0A00 + 16'(i), 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 3'd0, 1'b0);
        drive(1'b0, '0, 1'b1, 3'd7, 1'b0);
        idle(3);

        drive(1'b1, 16'h0B00, 1'b1, 3'd7, 1'b0);
        drive(1'b0, '0, 1'b1, 3'd7, 1'b0);
        drive(1'b0, '0, 1'b1, 3'd0, 1'b0);
        idle(3);

        drive(1'b0, '0, 1'b1, 3'd0, 1'b0);
        drive(1'b1, 16'h1234, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 16'h5555, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 3'd0, 1'b0);
        idle(3);

        drive(1'b0, '0, 1'b0, '0, 1'b1);
        idle(5);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        idle(10);
        drive(1'b0, '0, 1'b1, 3'd0, 1'b0);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                  AB'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 63) == 0));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end by 200000");
        $fatal(1, "watchdog");
    end

endmodule
